// File: rtl/add_result_buffer.sv
// add_result_buffer: 4-entry in-order FIFO holding {carry,sum} adder results.
// Ports: CLK/RST (sync, active-high), in_valid/S_in/C_in/in_ready push side,
// iso_en (isolate upstream), ret_en (freeze state, wins over RST),
// out_valid/out_ready/out_sum/out_carry pop side, count (0..4).
// Optional: define ADDBUF_DROP_CNT_EN to add drop_cnt[7:0], a saturating
// count of cycles where a valid, non-isolated input was refused.
module add_result_buffer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [31:0] S_in,
  input  logic        C_in,
  output logic        in_ready,
  input  logic        iso_en,
  input  logic        ret_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_carry,
  output logic [2:0]  count
`ifdef ADDBUF_DROP_CNT_EN
  ,
  output logic [7:0]  drop_cnt
`endif
);

  logic [32:0] mem_q [4];
  logic [32:0] mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        full, empty;
  logic        push, pop;

  always_comb begin
    full      = (count_q == 3'd4);
    empty     = (count_q == 3'd0);
    in_ready  = !full && !ret_en;
    out_valid = !empty && !ret_en;
    // iso_en gates first so an X on in_valid cannot leak into state
    push      = !iso_en && in_valid && in_ready;
    pop       = out_valid && out_ready;
    count     = count_q;
    {out_carry, out_sum} = empty ? 33'd0 : mem_q[rd_ptr_q];
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {C_in, S_in};
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Retention outranks reset; a reset cycle drops any push/pop.
  always_ff @(posedge CLK) begin
    if (RST && !ret_en) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; pointers/count define validity.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      mem_q <= mem_d;
    end
  end

`ifdef ADDBUF_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (!ret_en && in_valid && !iso_en && !in_ready &&
        drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
    drop_cnt = drop_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (RST && !ret_en) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_add_result_buffer.sv
// tb_add_result_buffer: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then random traffic.
module tb_add_result_buffer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] S_in = 32'd0;
  logic        C_in = 1'b0;
  logic        in_ready;
  logic        iso_en = 1'b0;
  logic        ret_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic        out_carry;
  logic [2:0]  count;
`ifdef ADDBUF_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  add_result_buffer dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .S_in(S_in), .C_in(C_in),
    .in_ready(in_ready), .iso_en(iso_en), .ret_en(ret_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .count(count)
`ifdef ADDBUF_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  logic [32:0] q[$];
  int          m_drop = 0;

  task automatic chk(input string name, input logic [32:0] act,
                     input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, advanced at each rising edge.
  always @(posedge CLK) begin
    if (started) begin
      if (ret_en) begin
      end else if (RST) begin
        q.delete();
        m_drop = 0;
      end else begin
        bit full, do_push, do_pop;
        full    = (q.size() == 4);
        do_push = !iso_en && in_valid === 1'b1 && !full;
        do_pop  = (q.size() != 0) && out_ready;
        if (!iso_en && in_valid === 1'b1 && full && m_drop < 255)
          m_drop++;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({C_in, S_in});
      end
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      logic [32:0] head;
      head = (q.size() != 0) ? q[0] : 33'd0;
      chk("count", 33'(count), 33'(q.size()));
      chk("in_ready", 33'(in_ready), 33'((q.size() != 4) && !ret_en));
      chk("out_valid", 33'(out_valid), 33'((q.size() != 0) && !ret_en));
      chk("head", {out_carry, out_sum}, head);
`ifdef ADDBUF_DROP_CNT_EN
      chk("drop_cnt", 33'(drop_cnt), 33'(m_drop));
`endif
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic idle();
    RST = 0; in_valid = 0; iso_en = 0; ret_en = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    idle(); RST = 1; cyc(); RST = 0;
  endtask

  task automatic push(input logic [32:0] v);
    in_valid = 1; {C_in, S_in} = v; cyc(); in_valid = 0;
  endtask

  logic [32:0] vals [5];

  initial begin
    RST = 1;
    cyc(2);
    started = 1'b1;
    cyc();
    idle();
    #1;
    chk("rst_count", 33'(count), 33'd0);
    chk("rst_in_ready", 33'(in_ready), 33'd1);
    chk("rst_out", {out_valid, out_carry, out_sum}, 33'd0);

    // Single push latency and value
    push({1'b0, 32'h0000_0001});
    chk("p1_valid", 33'(out_valid), 33'd1);
    chk("p1_sum", 33'(out_sum), 33'd1);
    chk("p1_carry", 33'(out_carry), 33'd0);
    chk("p1_count", 33'(count), 33'd1);

    // Overfill: fifth push dropped, drain in order
    do_reset();
    for (int i = 0; i < 5; i++) begin
      vals[i] = {1'($urandom_range(0, 1)), 32'($urandom)};
      push(vals[i]);
    end
    chk("full_count", 33'(count), 33'd4);
    chk("full_ready", 33'(in_ready), 33'd0);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_val", {out_carry, out_sum}, vals[i]);
      cyc();
    end
    out_ready = 0;
    chk("drain_empty", 33'(out_valid), 33'd0);

    // Isolation with unknown data
    push({1'b1, 32'hDEAD_BEEF});
    iso_en = 1; in_valid = 1; S_in = 'x; C_in = 'x;
    cyc(3);
    chk("iso_count", 33'(count), 33'd1);
    chk("iso_known", 33'($isunknown({out_valid, out_sum, out_carry,
                                      in_ready, count})), 33'd0);
    chk("iso_head", {out_carry, out_sum}, {1'b1, 32'hDEAD_BEEF});
    idle();

    // Retention beats reset
    push({1'b0, 32'h1111_2222});
    ret_en = 1; RST = 1; cyc(); RST = 0;
    cyc();
    chk("ret_count", 33'(count), 33'd2);
    chk("ret_valid", 33'(out_valid), 33'd0);
    ret_en = 0; out_ready = 1;
    chk("ret_pop0", {out_carry, out_sum}, {1'b1, 32'hDEAD_BEEF});
    cyc();
    chk("ret_pop1", {out_carry, out_sum}, {1'b0, 32'h1111_2222});
    cyc();
    out_ready = 0;

    // Steady push+pop at depth 3 with pointer wrap
    do_reset();
    for (int i = 0; i < 3; i++) push({1'b0, 32'(i + 100)});
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      {C_in, S_in} = {1'b1, 32'(i + 200)};
      cyc();
    end
    idle();
    chk("steady_count", 33'(count), 33'd3);
    chk("steady_head", {out_carry, out_sum}, {1'b1, 32'd205});

`ifdef ADDBUF_DROP_CNT_EN
    do_reset();
    for (int i = 0; i < 4; i++) push({1'b0, 32'(i)});
    in_valid = 1;
    cyc(300);
    idle();
    chk("drop_sat", 33'(drop_cnt), 33'd255);
    ret_en = 1; RST = 1; cyc(); idle();
    chk("drop_ret", 33'(drop_cnt), 33'd255);
    do_reset();
    chk("drop_rst", 33'(drop_cnt), 33'd0);
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      RST       = ($urandom_range(0, 99) < 3);
      ret_en    = ($urandom_range(0, 99) < 10);
      iso_en    = ($urandom_range(0, 99) < 15);
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 50);
      S_in      = $urandom;
      C_in      = 1'($urandom_range(0, 1));
      cyc();
    end
    idle();
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_result_buffer.md
ADD_RESULT_BUFFER -- requirements
Module: add_result_buffer

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 SHALL have port CLK, input, 1, rising-edge clock.
REQ-003 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, adder result valid.
REQ-005 SHALL have port S_in, input, 32, adder sum.
REQ-006 SHALL have port C_in, input, 1, adder carry-out.
REQ-007 SHALL have port in_ready, output, 1, buffer can accept.
REQ-008 SHALL have port iso_en, input, 1, upstream adder isolated, inputs untrusted.
REQ-009 SHALL have port ret_en, input, 1, retention/freeze request.
REQ-010 SHALL have port out_valid, output, 1, head entry valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts.
REQ-012 SHALL have port out_sum, output, 32, head sum.
REQ-013 SHALL have port out_carry, output, 1, head carry.
REQ-014 SHALL have port count, output, 3, occupied entries, 0..4.

Function
REQ-015 SHALL buffer {C_in,S_in} in a 4-entry FIFO, 33 bits/entry, in order.
REQ-016 SHALL push on the rising edge when in_valid & in_ready & !iso_en.
REQ-017 SHALL pop on the rising edge when out_valid & out_ready.
REQ-018 SHALL drive in_ready = (count != 4) & !ret_en, combinationally.
REQ-019 SHALL drive out_valid = (count != 0) & !ret_en, combinationally.
REQ-020 SHALL present the head entry on out_sum/out_carry whenever count != 0, and 0 when empty.
REQ-021 SHALL have no bypass: a push is visible on out_valid one cycle later (latency 1).
REQ-022 SHALL allow simultaneous push and pop with count unchanged, when not full and not empty.
REQ-023 SHALL ignore in_valid while full, with no push, no data corruption and count held at 4.
REQ-024 SHALL ignore in_valid and S_in/C_in entirely while iso_en=1, regardless of their values including X.
REQ-025 SHALL freeze storage, pointers and count while ret_en=1, with no push and no pop.
REQ-026 SHALL use 2-bit read/write pointers that wrap 3->0; count SHALL be tracked separately to distinguish full from empty.

Reset
REQ-027 SHALL, when RST=1 and ret_en=0, clear count, pointers, out_valid=0, out_sum=0, out_carry=0 and in_ready=1 on the next edge.
REQ-028 SHALL, when RST=1 and ret_en=1, retain storage, pointers and count; retention has priority over reset.
REQ-029 SHALL NOT reset the storage array; only pointers and count are cleared.
REQ-030 SHALL discard a concurrent push or pop in the reset cycle.

Configuration
REQ-031 SHALL, when macro ADDBUF_DROP_CNT_EN is defined, add output drop_cnt[7:0], reset to 0, incrementing once per cycle with in_valid=1 & iso_en=0 & in_ready=0, saturating at 255, held during retention, and cleared by RST only when ret_en=0.
REQ-032 SHALL, without ADDBUF_DROP_CNT_EN, have no drop_cnt port and no counter logic.

Verification
REQ-033 SHALL cover: RST, then push S_in=32'h0000_0001,C_in=0 -> out_valid=1 next cycle, out_sum=1, out_carry=0, count=1.
REQ-034 SHALL cover: push 5 values A..E with out_ready=0 -> count=4, in_ready=0, E dropped; drain -> A,B,C,D in order, then out_valid=0.
REQ-035 SHALL cover: iso_en=1 with in_valid=1, S_in=X for 3 cycles -> count unchanged, no X on outputs.
REQ-036 SHALL cover: count=2, ret_en=1 with RST=1 pulsed -> count=2, out_valid=0; after ret_en=0, original two entries pop in order.
REQ-037 SHALL cover: count=3 with continuous push+pop for 8 cycles -> count stays 3, pointer wrap, output order preserved.
REQ-038 SHALL cover: with ADDBUF_DROP_CNT_EN, hold full with in_valid=1 for 300 cycles -> drop_cnt=255.
